jpeg_dec_pi_feeder: RTL and testbench

JPEG_DEC_PI_FEEDER -- requirements
Module: jpeg_dec_pi_feeder

---
 rtl/jpeg_dec_pi_feeder_if.sv | 24 ++
 rtl/jpeg_dec_pi_feeder.sv | 181 ++++++++++++++++++
 tb/tb_jpeg_dec_pi_feeder.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/jpeg_dec_pi_feeder_if.sv
// Byte-in / word-out handshake bundle for the JPEG ECS feeder.
// The slave side is the feeder; the master side is the byte source plus the VLD.
interface jpeg_dec_pi_feeder_if #(
  parameter int PI_W = 32
);
  logic            BS_EN;
  logic [7:0]      BS_DAT;
  logic            BS_RDY;
  logic            PI_EMPTY;
  logic            PI_REQ;
  logic [PI_W-1:0] PI;
  logic            PI_RST_MRK;
  logic            PI_EOI_MRK;

  modport master (
    output BS_EN, BS_DAT, PI_REQ,
    input  BS_RDY, PI_EMPTY, PI, PI_RST_MRK, PI_EOI_MRK
  );

  modport slave (
    input  BS_EN, BS_DAT, PI_REQ,
    output BS_RDY, PI_EMPTY, PI, PI_RST_MRK, PI_EOI_MRK
  );
endinterface

// File: rtl/jpeg_dec_pi_feeder.sv
// JPEG ECS byte unstuffer and word packer.
// Removes 0xFF00 stuffing and 0xFF fill bytes, packs payload bytes MSB-first into
// 32-bit words, and closes the current word at RSTn / EOI markers with 0xFF padding
// and a marker flag. Words queue in a small first-word-fall-through FIFO for the VLD.
//
//   state  | meaning
//   S_DATA | plain payload bytes; 0xFF opens a marker/stuffing sequence
//   S_FF   | previous byte was 0xFF; next byte decides stuffing, fill or marker
//   S_DONE | EOI seen; input stalled until INIT or HRESET
module jpeg_dec_pi_feeder #(
  parameter int PI_W  = 32,
  parameter int FD_AW = 2
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 INIT,
  output logic                 MRK_ERR,
  jpeg_dec_pi_feeder_if.slave  bus
);

  localparam int               DEPTH     = 1 << FD_AW;
  localparam logic [FD_AW:0]   DEPTH_CNT = (FD_AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_DATA, S_FF, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [23:0]       asm_q, asm_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [2:0]        ridx_q, ridx_d;
  logic              err_q, err_d;

  logic [PI_W-1:0]   mem_q [DEPTH];
  logic [DEPTH-1:0]  rmk_q, emk_q;
  logic [FD_AW-1:0]  wptr_q, rptr_q;
  logic [FD_AW:0]    fcnt_q;

  logic              clr;
  logic              acc;
  logic              pop;
  logic              push;
  logic [PI_W-1:0]   push_word;
  logic              push_rst;
  logic              push_eoi;
  logic              append;
  logic              marker;
  logic [7:0]        app_byte;
  logic              empty;

  assign clr   = HRESET | INIT;
  assign empty = (fcnt_q == '0);

  // A byte is only offered room when the FIFO can absorb the one word it might complete.
  assign bus.BS_RDY     = (fcnt_q < DEPTH_CNT) && (state_q != S_DONE);
  assign acc            = bus.BS_EN & bus.BS_RDY;
  assign pop            = bus.PI_REQ & ~empty;
  assign bus.PI_EMPTY   = empty;
  assign bus.PI         = mem_q[rptr_q];
  assign bus.PI_RST_MRK = rmk_q[rptr_q] & ~empty;
  assign bus.PI_EOI_MRK = emk_q[rptr_q] & ~empty;
  assign MRK_ERR        = err_q;

  // Byte decode, word assembly and marker handling for the accepted byte.
  always_comb begin
    state_d   = state_q;
    asm_d     = asm_q;
    bcnt_d    = bcnt_q;
    ridx_d    = ridx_q;
    err_d     = err_q;
    append    = 1'b0;
    marker    = 1'b0;
    app_byte  = bus.BS_DAT;
    push      = 1'b0;
    push_word = '0;
    push_rst  = 1'b0;
    push_eoi  = 1'b0;

    if (acc) begin
      unique case (state_q)
        S_DATA: begin
          if (bus.BS_DAT == 8'hFF) state_d = S_FF;
          else                     append  = 1'b1;
        end
        S_FF: begin
          if (bus.BS_DAT == 8'h00) begin
            append   = 1'b1;
            app_byte = 8'hFF;
            state_d  = S_DATA;
          end else if (bus.BS_DAT == 8'hFF) begin
            state_d = S_FF;
          end else if (bus.BS_DAT[7:3] == 5'b11010) begin
            marker   = 1'b1;
            push_rst = 1'b1;
            state_d  = S_DATA;
            if (bus.BS_DAT[2:0] != ridx_q) err_d = 1'b1;
            // Resync to the received index so one lost marker flags only once.
            ridx_d   = bus.BS_DAT[2:0] + 3'd1;
          end else if (bus.BS_DAT == 8'hD9) begin
            marker   = 1'b1;
            push_eoi = 1'b1;
            state_d  = S_DONE;
          end else begin
            err_d   = 1'b1;
            state_d = S_DATA;
          end
        end
        default: state_d = state_q;
      endcase
    end

    if (append) begin
      if (bcnt_q == 2'd3) begin
        push      = 1'b1;
        push_word = {asm_q, app_byte};
        bcnt_d    = 2'd0;
      end else begin
        unique case (bcnt_q)
          2'd0:    asm_d[23:16] = app_byte;
          2'd1:    asm_d[15:8]  = app_byte;
          default: asm_d[7:0]   = app_byte;
        endcase
        bcnt_d = bcnt_q + 2'd1;
      end
    end

    // Markers always close exactly one word; unfilled low bytes read as 0xFF.
    if (marker) begin
      push   = 1'b1;
      bcnt_d = 2'd0;
      unique case (bcnt_q)
        2'd0:    push_word = 32'hFFFF_FFFF;
        2'd1:    push_word = {asm_q[23:16], 24'hFF_FFFF};
        2'd2:    push_word = {asm_q[23:8], 16'hFFFF};
        default: push_word = {asm_q, 8'hFF};
      endcase
    end
  end

  // Byte FSM and assembly registers.
  always_ff @(posedge HCLK) begin
    if (clr) begin
      state_q <= S_DATA;
      asm_q   <= '0;
      bcnt_q  <= '0;
      ridx_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      asm_q   <= asm_d;
      bcnt_q  <= bcnt_d;
      ridx_q  <= ridx_d;
      err_q   <= err_d;
    end
  end

  // FIFO storage; contents are irrelevant while empty, so no reset is needed.
  always_ff @(posedge HCLK) begin
    if (push) begin
      mem_q[wptr_q] <= push_word;
      rmk_q[wptr_q] <= push_rst;
      emk_q[wptr_q] <= push_eoi;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge HCLK) begin
    if (clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + FD_AW'(1);
      if (pop)  rptr_q <= rptr_q + FD_AW'(1);
      unique case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + (FD_AW+1)'(1);
        2'b01:   fcnt_q <= fcnt_q - (FD_AW+1)'(1);
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg_dec_pi_feeder.sv
// Scoreboard bench for the JPEG ECS feeder: stimulus queues expected words,
// a monitor process acts as the VLD and checks every popped word.
module tb_jpeg_dec_pi_feeder;

  logic HCLK = 1'b0;
  logic HRESET;
  logic INIT;
  logic MRK_ERR;

  jpeg_dec_pi_feeder_if #(.PI_W(32)) bus ();

  jpeg_dec_pi_feeder #(.PI_W(32), .FD_AW(2)) dut (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .INIT    (INIT),
    .MRK_ERR (MRK_ERR),
    .bus     (bus.slave)
  );

  always #5 HCLK = ~HCLK;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [33:0] exp_q [$];
  bit          drain_en = 1'b0;

  function automatic logic [33:0] mk(input logic [31:0] w, input logic r, input logic e);
    return {e, r, w};
  endfunction

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] w, input logic r, input logic e);
    exp_q.push_back(mk(w, r, e));
  endtask

  // Consumer / monitor: pops whenever enabled and a word is present.
  initial begin
    bus.PI_REQ = 1'b0;
    forever begin
      @(negedge HCLK);
      if (drain_en && !bus.PI_EMPTY && !HRESET && !INIT) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got %h expected none",
                   {bus.PI_EOI_MRK, bus.PI_RST_MRK, bus.PI});
        end else begin
          chk("pi_word", {bus.PI_EOI_MRK, bus.PI_RST_MRK, bus.PI}, exp_q.pop_front());
        end
        bus.PI_REQ = 1'b1;
      end else begin
        bus.PI_REQ = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge HCLK);
    bus.BS_EN  = 1'b1;
    bus.BS_DAT = b;
    while (!bus.BS_RDY && t < 200) begin
      @(negedge HCLK);
      t++;
    end
    if (t >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: byte %h not accepted, expected acceptance", b);
    end
    @(posedge HCLK);
    #1;
    bus.BS_EN = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s [$]);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !bus.PI_EMPTY) && t < 100) begin
      @(negedge HCLK);
      t++;
    end
    if (t >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d words still expected, expected 0", exp_q.size());
    end
  endtask

  task automatic init_pulse();
    @(negedge HCLK);
    INIT = 1'b1;
    @(negedge HCLK);
    INIT = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET     = 1'b1;
    INIT       = 1'b0;
    bus.BS_EN  = 1'b0;
    bus.BS_DAT = 8'h00;
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;

    // Reset state
    chk("rst_bs_rdy",   bus.BS_RDY,   1);
    chk("rst_pi_empty", bus.PI_EMPTY, 1);
    chk("rst_mrk_err",  MRK_ERR,      0);
    chk("rst_flags",    {bus.PI_EOI_MRK, bus.PI_RST_MRK}, 0);

    // 12 34 56 78 9A with no pops: latency and hold checks
    send_seq('{8'h12, 8'h34, 8'h56});
    chk("no_early_push", bus.PI_EMPTY, 1);
    send_byte(8'h78);
    chk("latency_empty", bus.PI_EMPTY, 0);
    chk("latency_word",  {bus.PI_EOI_MRK, bus.PI_RST_MRK, bus.PI}, mk(32'h12345678, 0, 0));
    send_byte(8'h9A);
    chk("hold_word", bus.PI, 32'h12345678);
    expect_word(32'h12345678, 0, 0);
    drain_en = 1'b1;
    wait_drain();
    repeat (3) @(negedge HCLK);
    chk("partial_held", bus.PI_EMPTY, 1);
    init_pulse();

    // Stuffed 0xFF00
    expect_word(32'hABFFCDEF, 0, 0);
    send_seq('{8'hAB, 8'hFF, 8'h00, 8'hCD, 8'hEF});
    wait_drain();

    // Fill bytes then RST0 on a 1-byte partial
    expect_word(32'hABFFFFFF, 1, 0);
    send_seq('{8'hAB, 8'hFF, 8'hFF, 8'hFF, 8'hD0});
    wait_drain();
    chk("rst0_no_err", MRK_ERR, 0);

    // RST1 on a 2-byte partial, in sequence
    expect_word(32'h1122FFFF, 1, 0);
    send_seq('{8'h11, 8'h22, 8'hFF, 8'hD1});
    wait_drain();
    chk("rst1_no_err", MRK_ERR, 0);

    // EOI on an empty assembly, then stall until INIT
    init_pulse();
    expect_word(32'h11223344, 0, 0);
    expect_word(32'hFFFFFFFF, 0, 1);
    send_seq('{8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 8'hD9});
    wait_drain();
    @(negedge HCLK);
    bus.BS_EN  = 1'b1;
    bus.BS_DAT = 8'h55;
    repeat (4) @(negedge HCLK);
    bus.BS_EN = 1'b0;
    chk("done_bs_rdy",   bus.BS_RDY,   0);
    chk("done_no_push",  bus.PI_EMPTY, 1);
    init_pulse();
    chk("init_bs_rdy",   bus.BS_RDY,   1);

    // Fill the FIFO to depth with no pops
    drain_en = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    chk("full_bs_rdy", bus.BS_RDY,   0);
    chk("full_head",   bus.PI,       32'h00010203);
    for (int i = 0; i < 4; i++)
      expect_word({8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)}, 0, 0);
    expect_word(32'h10111213, 0, 0);
    drain_en = 1'b1;
    send_seq('{8'h10, 8'h11, 8'h12, 8'h13});
    wait_drain();

    // Push and pop in the same cycle
    drain_en = 1'b0;
    expect_word(32'h20212223, 0, 0);
    expect_word(32'h24252627, 0, 0);
    send_seq('{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26});
    drain_en = 1'b1;
    send_byte(8'h27);
    chk("pushpop_empty", bus.PI_EMPTY, 0);
    chk("pushpop_head",  bus.PI,       32'h24252627);
    wait_drain();

    // RST sequence error and illegal marker
    init_pulse();
    expect_word(32'hFFFFFFFF, 1, 0);
    expect_word(32'hFFFFFFFF, 1, 0);
    send_seq('{8'hFF, 8'hD0});
    chk("seq_d0_err", MRK_ERR, 0);
    send_seq('{8'hFF, 8'hD2});
    chk("seq_d2_err", MRK_ERR, 1);
    wait_drain();
    send_seq('{8'hFF, 8'h5A});
    repeat (3) @(negedge HCLK);
    chk("illegal_no_push", bus.PI_EMPTY, 1);
    chk("illegal_err",     MRK_ERR,      1);
    init_pulse();
    chk("init_clr_err", MRK_ERR, 0);

    // HRESET mid-FF-sequence discards pending bytes
    send_seq('{8'h01, 8'h02, 8'hFF});
    @(negedge HCLK);
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    expect_word(32'h03040506, 0, 0);
    send_seq('{8'h03, 8'h04, 8'h05, 8'h06});
    wait_drain();
    chk("rst_mid_err", MRK_ERR, 0);

    repeat (3) @(negedge HCLK);
    chk("queue_empty_end", 34'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
